// File: rtl/datamemory_sized_pkg.sv
// Shared definitions for the sized data memory: access size encodings,
// the clear/ready FSM state type and the byte-enable/alignment helper.
package datamemory_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam int MIN_READ_LATENCY = 1;
  localparam int MAX_READ_LATENCY = 4;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] be;
    logic       misalign;
  } lane_ctl_t;

  // Byte enables and misalign flag for an access of the given size at the
  // given byte lane. A misaligned or illegal access gets no byte enables.
  function automatic lane_ctl_t lane_ctl(input logic [1:0] size, input logic [1:0] lane);
    lane_ctl_t r;
    r.be       = 4'b0000;
    r.misalign = 1'b0;
    case (size)
      SIZE_BYTE: r.be = 4'b0001 << lane;
      SIZE_HALF: begin
        if (lane[0]) begin
          r.misalign = 1'b1;
        end else begin
          r.be = lane[1] ? 4'b1100 : 4'b0011;
        end
      end
      SIZE_WORD: begin
        if (lane != 2'b00) begin
          r.misalign = 1'b1;
        end else begin
          r.be = 4'b1111;
        end
      end
      default: r.misalign = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/datamemory_sized_if.sv
// Request/response bus of the sized data memory. The memory is the slave;
// the memory-stage logic (or a testbench) is the master.
interface datamemory_sized_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  resp_valid;
  logic [31:0]           resp_rdata;
  logic                  resp_error;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

endinterface

// File: rtl/datamemory_sized_align.sv
// Load alignment: picks the addressed byte or half-word out of a memory word,
// moves it to bit 0 and zero- or sign-extends it. Word loads pass through;
// an illegal size yields zero.
module datamemory_align
  import datamemory_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Lane select and extension of the loaded value
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    w_sign = 1'b0;
    o_data = 32'h0000_0000;
    case (i_lane)
      2'b00:   w_byte = i_word[7:0];
      2'b01:   w_byte = i_word[15:8];
      2'b10:   w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    if (i_lane[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
    case (i_size)
      SIZE_BYTE: begin
        w_sign = ~i_unsigned & w_byte[7];
        o_data = {{24{w_sign}}, w_byte};
      end
      SIZE_HALF: begin
        w_sign = ~i_unsigned & w_half[15];
        o_data = {{16{w_sign}}, w_half};
      end
      SIZE_WORD: o_data = i_word;
      default:   o_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/datamemory_sized.sv
// Word-organised 32-bit data memory with sized byte-addressed loads/stores.
// After reset a clear FSM zero-fills the array one word per cycle; only then
// are requests accepted. Responses come back in order READ_LATENCY cycles
// after acceptance through a flushable register pipeline.
module datamemory_sized
  import datamemory_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  datamemory_sized_if.slave bus
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  // Storage is not reset: the clear FSM owns initialisation.
  logic [31:0] r_mem [DEPTH];

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_clr_cnt;
  logic [IDX_W-1:0]   w_clr_cnt_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic               w_clear_we;

  logic               w_accept;
  logic [1:0]         w_lane;
  logic [IDX_W-1:0]   w_idx;
  lane_ctl_t          w_ctl;
  logic [31:0]        w_rd_word;
  logic [31:0]        w_wlanes;
  logic [31:0]        w_merged;
  logic               w_store_we;
  logic [31:0]        w_load_data;

  logic               w_s0_valid;
  logic               w_s0_error;
  logic [31:0]        w_s0_rdata;

  logic               r_pv [READ_LATENCY];
  logic               r_pe [READ_LATENCY];
  logic [31:0]        r_pd [READ_LATENCY];

  // Clear FSM state, clear counter and registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= {IDX_W{1'b0}};
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Clear FSM next state: walk every word once, then open for traffic
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clear_we    = 1'b0;
    case (r_state)
      CLEAR: begin
        w_clear_we = 1'b1;
        if (r_clr_cnt == LAST_IDX) begin
          w_state_nxt   = READY;
          w_clr_cnt_nxt = {IDX_W{1'b0}};
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + IDX_W'(1);
        end
      end
      READY: begin
        w_state_nxt = READY;
      end
      default: begin
        w_state_nxt   = CLEAR;
        w_clr_cnt_nxt = {IDX_W{1'b0}};
      end
    endcase
    w_ready_nxt = (w_state_nxt == READY);
  end

  // Request decode, array read and store data merge
  always_comb begin
    w_accept  = bus.req_valid & r_ready;
    w_lane    = bus.req_addr[1:0];
    w_idx     = bus.req_addr[ADDR_WIDTH-1:2];
    w_ctl     = lane_ctl(bus.req_size, w_lane);
    w_rd_word = r_mem[w_idx];
    w_wlanes  = bus.req_wdata;
    case (bus.req_size)
      SIZE_BYTE: w_wlanes = {4{bus.req_wdata[7:0]}};
      SIZE_HALF: w_wlanes = {2{bus.req_wdata[15:0]}};
      default:   w_wlanes = bus.req_wdata;
    endcase
    w_merged = w_rd_word;
    for (int b = 0; b < 4; b++) begin
      if (w_ctl.be[b]) begin
        w_merged[8*b +: 8] = w_wlanes[8*b +: 8];
      end else begin
        w_merged[8*b +: 8] = w_rd_word[8*b +: 8];
      end
    end
    w_store_we = w_accept & bus.req_write & ~w_ctl.misalign;
  end

  // Array write port: clear writes zero, otherwise a legal store commits
  always_ff @(posedge clk) begin
    if (w_clear_we) begin
      r_mem[r_clr_cnt] <= 32'h0000_0000;
    end else if (w_store_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  datamemory_align u_align (
    .i_word     (w_rd_word),
    .i_lane     (w_lane),
    .i_size     (bus.req_size),
    .i_unsigned (bus.req_unsigned),
    .o_data     (w_load_data)
  );

  // Response for the request being accepted, before the first stage
  always_comb begin
    w_s0_valid = w_accept;
    w_s0_error = w_accept & w_ctl.misalign;
    if (w_accept && !bus.req_write && !w_ctl.misalign) begin
      w_s0_rdata = w_load_data;
    end else begin
      w_s0_rdata = 32'h0000_0000;
    end
  end

  // Response pipeline: reset flushes every stage, responses in flight are lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pe[i] <= 1'b0;
        r_pd[i] <= 32'h0000_0000;
      end
    end else begin
      r_pv[0] <= w_s0_valid;
      r_pe[0] <= w_s0_error;
      r_pd[0] <= w_s0_rdata;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pe[i] <= r_pe[i-1];
        r_pd[i] <= r_pd[i-1];
      end
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.resp_valid = r_pv[READ_LATENCY-1];
  assign bus.resp_error = r_pe[READ_LATENCY-1];
  assign bus.resp_rdata = r_pd[READ_LATENCY-1];

endmodule

// File: tb/tb_datamemory_sized.sv
// Bench for datamemory_sized: directed and random requests checked against a
// byte-array reference model and an in-order expected-response queue that
// also carries the cycle each response is due.
module tb_datamemory_sized;

  localparam int AW     = 6;
  localparam int RL     = 3;
  localparam int NBYTES = 2 ** AW;
  localparam int NWORDS = NBYTES / 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  datamemory_sized_if #(.ADDR_WIDTH(AW)) bus ();

  datamemory_sized #(.ADDR_WIDTH(AW), .READ_LATENCY(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t       expq [$];
  logic [7:0] mm [NBYTES];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference behaviour on a little-endian byte array
  task automatic model_access(input logic w, input logic [1:0] sz, input logic uns,
                              input int addr, input logic [31:0] wd,
                              output logic [31:0] rd, output logic err);
    int     n;
    longint v;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || ((addr % n) != 0);
    rd  = 32'h0;
    if (!err) begin
      if (w) begin
        for (int i = 0; i < n; i++) mm[addr + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v = v | (longint'(mm[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8 * n));
        rd = v[31:0];
      end
    end
  endtask

  task automatic model_zero();
    for (int i = 0; i < NBYTES; i++) mm[i] = 8'h00;
  endtask

  // Called at a negedge; leaves req_valid high and returns at the next negedge
  task automatic send(input logic w, input logic [1:0] sz, input logic uns,
                      input int addr, input logic [31:0] wd);
    int          guard;
    exp_t        e;
    logic [31:0] rd;
    logic        er;
    guard            = 0;
    bus.req_valid    = 1'b1;
    bus.req_write    = w;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = AW'(addr);
    bus.req_wdata    = wd;
    while (bus.req_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (bus.req_ready !== 1'b1) begin
      chk("req_ready_timeout", 32'(bus.req_ready), 32'h1);
      bus.req_valid = 1'b0;
    end else begin
      model_access(w, sz, uns, addr, wd, rd, er);
      e.due   = cyc + RL;
      e.rdata = rd;
      e.err   = er;
      expq.push_back(e);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int g;
    g             = 0;
    bus.req_valid = 1'b0;
    while (expq.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", 32'(expq.size()), 32'h0);
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n), 32'(NWORDS));
  endtask

  // Response monitor: order, timing, data and error of every response
  always @(negedge clk) begin
    exp_t e;
    if (bus.resp_valid === 1'b1) begin
      if (expq.size() == 0) begin
        chk("spurious_resp", 32'(bus.resp_valid), 32'h0);
      end else begin
        e = expq.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        chk("resp_rdata", bus.resp_rdata, e.rdata);
        chk("resp_error", 32'(bus.resp_error), 32'(e.err));
      end
    end else if (expq.size() > 0 && expq[0].due <= cyc) begin
      e = expq.pop_front();
      chk("resp_missing", 32'(bus.resp_valid), 32'h1);
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] sz;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = 32'h0;
    model_zero();

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'h0);

    // Clear period, then every word reads back zero
    rst_n = 1'b1;
    count_clear("clear_cycles");
    for (int a = 0; a < NBYTES; a += 4) send(1'b0, 2'b10, 1'b0, a, 32'h0);
    drain();

    // Word store then signed/unsigned byte loads, store-then-load back to back
    send(1'b1, 2'b10, 1'b0, 8, 32'hDEADBEEF);
    for (int a = 8; a < 12; a++) send(1'b0, 2'b00, 1'b0, a, 32'h0);
    send(1'b0, 2'b00, 1'b1, 11, 32'h0);
    send(1'b0, 2'b01, 1'b0, 10, 32'h0);
    send(1'b0, 2'b01, 1'b1, 10, 32'h0);
    // Partial stores keep untouched lanes
    send(1'b1, 2'b00, 1'b0, 9, 32'hFFFFFF55);
    send(1'b0, 2'b10, 1'b0, 8, 32'h0);
    send(1'b1, 2'b01, 1'b0, 10, 32'hABCD1234);
    send(1'b0, 2'b10, 1'b0, 8, 32'h0);
    drain();

    // Misaligned and illegal accesses
    send(1'b1, 2'b10, 1'b0, 4, 32'h01020304);
    send(1'b0, 2'b01, 1'b0, 3, 32'h0);
    send(1'b0, 2'b10, 1'b0, 6, 32'h0);
    send(1'b1, 2'b10, 1'b0, 5, 32'hCAFEF00D);
    send(1'b0, 2'b10, 1'b0, 4, 32'h0);
    send(1'b1, 2'b11, 1'b0, 4, 32'h11111111);
    send(1'b0, 2'b11, 1'b0, 0, 32'h0);
    send(1'b0, 2'b10, 1'b0, 4, 32'h0);
    drain();

    // Random traffic with random gaps
    for (int k = 0; k < 300; k++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      send(1'($urandom), sz, 1'($urandom), int'($urandom_range(0, NBYTES - 1)), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        bus.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    drain();

    // Reset with two responses in flight
    send(1'b0, 2'b10, 1'b0, 8, 32'h0);
    send(1'b0, 2'b10, 1'b0, 4, 32'h0);
    bus.req_valid = 1'b0;
    rst_n         = 1'b0;
    expq.delete();
    model_zero();
    repeat (2) @(negedge clk);
    chk("rst2_resp_valid", 32'(bus.resp_valid), 32'h0);
    chk("rst2_req_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    count_clear("clear_cycles_again");
    repeat (4) @(negedge clk);
    for (int a = 0; a < NBYTES; a += 4) send(1'b0, 2'b10, 1'b0, a, 32'h0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
